bool_share_n8: RTL and testbench
================================

# bool_share_n8

Serial Boolean masking encoder: takes one K_WIDTH-bit cleartext word and produces N_SHARES Boolean shares whose XOR equals the input. It consumes one fresh random word per cycle. It is the sharing end of the masked datapath: it feeds N-share Boolean inputs into the masked B2A/XOR pipelines, whose unmasking stage recombines the shares by XOR.

## Interface
- K_WIDTH, 32, bit width of each share and of the cleartext word.
- N_SHARES, 8, number of output shares. Must be ≥ 2.
- MASKWIDTH, K_WIDTH*N_SHARES, width of the packed share bus.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global enable. When 0, all state is frozen.
- dvld  in  1  input valid. Accepted only when ready=1 and ena=1.
- i_x  in  K_WIDTH  cleartext word, sampled on acceptance.
- ready  out  1  high only in IDLE; combinational from state.
- rnd  in  K_WIDTH  fresh random word, sampled on every edge where rnd_req=1.
- rnd_req  out  1  combinational: (state==GEN) && ena.
- o_z  out  MASKWIDTH  registered share bank. Share i is o_z[i*K_WIDTH +: K_WIDTH].
- ovld  out  1  registered; high while o_z holds a freshly completed encoding.

## Operation
- **States:** IDLE, GEN, DONE. Counter cnt has width $clog2(N_SHARES) and ranges 0..N_SHARES-2. Accumulator acc is K_WIDTH bits. Internal share bank sh is MASKWIDTH bits.
- **IDLE:** ready=1. On dvld&&ena:
  - acc ← i_x, cnt ← 0
  - go to GEN.
- **GEN:** on each edge with ena=1:
  - sh[cnt] ← rnd
  - acc ← acc ^ rnd
  - cnt ← cnt+1
- **Last GEN cycle (cnt==N_SHARES-2), with ena=1:**
  - sh[N-2] ← rnd and sh[N-1] ← acc ^ rnd.
  - o_z ← the complete bank, i.e. shares 0..N-2 equal to the rnd words in arrival order, and share N-1 equal to x ^ rnd0 ^ … ^ rnd(N-2).
  - acc ← 0 (zeroise the secret), cnt ← 0.
  - Go to DONE.
- **DONE:** ovld=1. On an edge with ena=1, go to IDLE.
- **o_z update rule:** o_z changes only on the last-GEN-cycle transition. Partial share sets never appear on o_z. o_z holds its value until the next completion.
- **ena=0:** state, cnt, acc, sh, o_z and ovld all hold, and rnd_req=0. No random word is consumed.
- **dvld while ready=0:** ignored. It is not queued and has no effect on the encoding in progress.
- **Reset** (at any time, including mid-GEN):
  - state=IDLE, cnt=0, acc=0, sh=0, o_z=0, ovld=0.
  - Combinational outputs take ready=1 and rnd_req=0.
  - A partially generated encoding is discarded and never signalled.

## Timing
- An encoding is accepted on the edge ending cycle t (IDLE, dvld=ena=1).
- GEN occupies cycles t+1 … t+N_SHARES-1 (7 cycles for N=8), with rnd_req=1 in each.
- DONE is cycle t+N_SHARES: ovld=1 and o_z valid. Latency is N_SHARES cycles from acceptance to ovld, plus one cycle for every ena=0 cycle.
- IDLE returns at cycle t+N_SHARES+1. Maximum throughput is one encoding per N_SHARES+1 cycles.
- ovld is high for exactly one ena=1 cycle, and stays high through any ena=0 cycles while in DONE.
- rnd must be valid in the same cycle as rnd_req. No rnd word is used twice.

## Test plan
- **Basic encoding.** N=8, i_x=0xDEADBEEF; rnd supplies 0x00000001…0x00000007 on successive rnd_req cycles.
  - Required: ovld at accept+8, shares 0..6 = 0x1..0x7, share 7 = 0xDEADBEEF (XOR of 1..7 is 0).
  - XOR of all shares = 0xDEADBEEF.
- **All-ones randomness.** i_x=0x12345678, rnd=0xFFFFFFFF throughout.
  - Required: shares 0..6 = 0xFFFFFFFF, share 7 = 0xEDCBA987.
  - rnd_req high for exactly 7 cycles.
- **Stall.** Same stimulus as the basic encoding, with ena=0 for 3 cycles while cnt=3.
  - Required: rnd_req=0 during the stall, ovld at accept+11, o_z identical to the basic-encoding result.
- **Busy input ignored.** Pulse dvld with i_x=0xCAFEBABE during GEN of an encoding of 0xDEADBEEF.
  - Required: o_z unchanged from the basic-encoding result; ready=0 until IDLE; no second ovld.
- **Back-to-back.** Hold dvld=1 with i_x=0xA5A5A5A5.
  - Required: acceptances exactly 9 cycles apart; ovld pulses exactly 9 cycles apart; each result XORs to 0xA5A5A5A5.
- **Reset mid-operation.** Assert rst asynchronously while cnt=4.
  - Required: o_z=0, ovld=0, ready=1 immediately.
  - No ovld follows.
  - A new encoding of 0xDEADBEEF then completes correctly.

Source files
------------

// File: rtl/bool_share_n8.sv
// Serial Boolean masking encoder: splits one cleartext word into N_SHARES
// Boolean shares whose XOR equals the input. One fresh random word is
// consumed per GEN cycle.
module bool_share_n8 #(
    parameter int unsigned K_WIDTH   = 32,
    parameter int unsigned N_SHARES  = 8,
    parameter int unsigned MASKWIDTH = K_WIDTH * N_SHARES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 dvld,
    input  logic [K_WIDTH-1:0]   i_x,
    output logic                 ready,
    input  logic [K_WIDTH-1:0]   rnd,
    output logic                 rnd_req,
    output logic [MASKWIDTH-1:0] o_z,
    output logic                 ovld
);

    localparam int unsigned CNT_W = $clog2(N_SHARES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SHARES - 2);
    localparam logic [CNT_W-1:0] IDX_TOP  = CNT_W'(N_SHARES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                                state, state_nxt;
    logic [CNT_W-1:0]                      cnt, cnt_nxt;
    logic [K_WIDTH-1:0]                    acc, acc_nxt;
    logic [N_SHARES-1:0][K_WIDTH-1:0]      sh, sh_nxt;
    logic [MASKWIDTH-1:0]                  oz_nxt;
    logic                                  ovld_nxt;

    // Handshake outputs decoded straight from the state
    assign ready   = (state == IDLE);
    assign rnd_req = (state == GEN) && ena;

    // State and datapath registers; async reset also discards any partial encoding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            sh    <= '0;
            o_z   <= '0;
            ovld  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            sh    <= sh_nxt;
            o_z   <= oz_nxt;
            ovld  <= ovld_nxt;
        end
    end

    // Next-state and datapath; everything holds while ena is low
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        sh_nxt    = sh;
        oz_nxt    = o_z;
        ovld_nxt  = ovld;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (dvld) begin
                        acc_nxt   = i_x;
                        cnt_nxt   = '0;
                        state_nxt = GEN;
                    end
                end
                GEN: begin
                    sh_nxt[cnt] = rnd;
                    if (cnt == CNT_LAST) begin
                        // Last share closes the XOR; publish the whole bank at once
                        sh_nxt[IDX_TOP] = acc ^ rnd;
                        oz_nxt          = MASKWIDTH'(sh_nxt);
                        acc_nxt         = '0;
                        cnt_nxt         = '0;
                        ovld_nxt        = 1'b1;
                        state_nxt       = DONE;
                    end else begin
                        acc_nxt = acc ^ rnd;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    ovld_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bool_share_n8.sv
// Self-checking bench for bool_share_n8: directed table, randomized records,
// and hand-written back-to-back / reset sequences.
module tb_bool_share_n8;

    localparam int unsigned K  = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned MW = K * N;
    localparam int unsigned NV = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          dvld;
    logic [K-1:0]  i_x;
    logic [K-1:0]  rnd;
    logic          ready;
    logic          rnd_req;
    logic [MW-1:0] o_z;
    logic          ovld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bool_share_n8 #(.K_WIDTH(K), .N_SHARES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .dvld    (dvld),
        .i_x     (i_x),
        .ready   (ready),
        .rnd     (rnd),
        .rnd_req (rnd_req),
        .o_z     (o_z),
        .ovld    (ovld)
    );

    typedef struct packed {
        logic [K-1:0]          x;
        logic [N-2:0][K-1:0]   w;
        int                    stall_at;
        int                    stall_len;
        logic                  busy;
        int                    done_hold;
        logic [K-1:0]          exp_last;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: last share is the cleartext XORed with every random word
    function automatic logic [K-1:0] ref_last(input logic [K-1:0] x, input logic [N-2:0][K-1:0] w);
        logic [K-1:0] r;
        r = x;
        for (int i = 0; i < int'(N) - 1; i++) r = r ^ w[i];
        return r;
    endfunction

    function automatic logic [K-1:0] xor_all(input logic [MW-1:0] z);
        logic [K-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) r = r ^ z[i*K +: K];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full encoding from IDLE, with optional stall, busy pulse and DONE hold
    task automatic run_encode(input vec_t v, input string tag);
        logic [MW-1:0] exp_bank;
        int k;
        int stalled;
        exp_bank = {v.exp_last, v.w};
        k = 0;
        stalled = 0;
        ena = 1'b1;
        dvld = 1'b1;
        i_x = v.x;
        rnd = $urandom;
        #1;
        chk({tag, " ready_idle"}, MW'(ready), MW'(1));
        tick();
        while (k < int'(N) - 1) begin
            if (k == v.stall_at && stalled < v.stall_len) begin
                ena = 1'b0;
                rnd = $urandom;
                stalled++;
            end else begin
                ena = 1'b1;
                rnd = v.w[k];
                k++;
            end
            if (v.busy && k >= 2 && k <= 3) begin
                dvld = 1'b1;
                i_x = 32'hCAFEBABE;
            end else begin
                dvld = 1'b0;
                i_x = $urandom;
            end
            #1;
            chk({tag, " rnd_req"}, MW'(rnd_req), MW'(ena));
            chk({tag, " ready_gen"}, MW'(ready), MW'(0));
            chk({tag, " ovld_early"}, MW'(ovld), MW'(0));
            tick();
        end
        dvld = 1'b0;
        for (int h = 0; h <= v.done_hold; h++) begin
            ena = (h == v.done_hold);
            rnd = $urandom;
            #1;
            chk({tag, " ovld_done"}, MW'(ovld), MW'(1));
            chk({tag, " o_z"}, o_z, exp_bank);
            chk({tag, " xor"}, MW'(xor_all(o_z)), MW'(v.x));
            chk({tag, " rnd_req_done"}, MW'(rnd_req), MW'(0));
            chk({tag, " ready_done"}, MW'(ready), MW'(0));
            tick();
        end
        ena = 1'b1;
        #1;
        chk({tag, " ovld_clear"}, MW'(ovld), MW'(0));
        chk({tag, " ready_back"}, MW'(ready), MW'(1));
    endtask

    initial begin
        rst  = 1'b0;
        ena  = 1'b1;
        dvld = 1'b0;
        i_x  = '0;
        rnd  = '0;

        // Directed records
        for (int i = 0; i < 4; i++) begin
            tbl[i].x = 32'hDEADBEEF;
            for (int j = 0; j < int'(N) - 1; j++) tbl[i].w[j] = K'(j + 1);
            tbl[i].stall_at  = -1;
            tbl[i].stall_len = 0;
            tbl[i].busy      = 1'b0;
            tbl[i].done_hold = 0;
            tbl[i].exp_last  = 32'hDEADBEEF;
        end
        tbl[1].x = 32'h12345678;
        for (int j = 0; j < int'(N) - 1; j++) tbl[1].w[j] = 32'hFFFFFFFF;
        tbl[1].exp_last = 32'hEDCBA987;
        tbl[2].stall_at  = 3;
        tbl[2].stall_len = 3;
        tbl[2].done_hold = 2;
        tbl[3].busy      = 1'b1;
        // Randomized records checked against the reference
        for (int i = 4; i < int'(NV); i++) begin
            tbl[i].x = $urandom;
            for (int j = 0; j < int'(N) - 1; j++) tbl[i].w[j] = $urandom;
            tbl[i].stall_at  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 6));
            tbl[i].stall_len = int'($urandom_range(1, 4));
            tbl[i].busy      = 1'($urandom_range(0, 1));
            tbl[i].done_hold = int'($urandom_range(0, 2));
            tbl[i].exp_last  = ref_last(tbl[i].x, tbl[i].w);
        end

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("reset o_z", o_z, '0);
        chk("reset ovld", MW'(ovld), MW'(0));
        chk("reset ready", MW'(ready), MW'(1));
        chk("reset rnd_req", MW'(rnd_req), MW'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < int'(NV); i++) begin
            run_encode(tbl[i], $sformatf("vec%0d", i));
            tick();
        end

        // Back-to-back with dvld held high
        for (int c = 0; c <= 36; c++) begin
            ena  = 1'b1;
            dvld = (c <= 27);
            i_x  = 32'hA5A5A5A5;
            rnd  = $urandom;
            #1;
            chk($sformatf("b2b ready c%0d", c), MW'(ready), MW'(c % 9 == 0));
            chk($sformatf("b2b ovld c%0d", c), MW'(ovld), MW'(c % 9 == 8));
            chk($sformatf("b2b rnd_req c%0d", c), MW'(rnd_req), MW'((c % 9 >= 1) && (c % 9 <= 7)));
            if (c % 9 == 8) chk($sformatf("b2b xor c%0d", c), MW'(xor_all(o_z)), MW'(32'hA5A5A5A5));
            tick();
        end
        dvld = 1'b0;

        // Reset in the middle of GEN (cnt=4)
        ena  = 1'b1;
        dvld = 1'b1;
        i_x  = 32'hDEADBEEF;
        tick();
        dvld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rnd = K'(k + 1);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst o_z", o_z, '0);
        chk("midrst ovld", MW'(ovld), MW'(0));
        chk("midrst ready", MW'(ready), MW'(1));
        chk("midrst rnd_req", MW'(rnd_req), MW'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            rnd = $urandom;
            #1;
            chk($sformatf("midrst no_ovld c%0d", c), MW'(ovld), MW'(0));
            chk($sformatf("midrst idle c%0d", c), MW'(ready), MW'(1));
            tick();
        end
        run_encode(tbl[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
